// File: rtl/decode_in_txn_driver.sv
// Transaction driver for the LC3 decode-stage input: buffers {instr, npc, gap}
// transactions in a small FIFO and replays them as single-cycle enabled beats.
module decode_in_txn_driver #(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned NPC_W     = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned GAP_W     = 4,
    parameter bit          STICKY_EN = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       txn_valid,
    output logic                       txn_ready,
    input  logic [INSTR_W-1:0]         txn_instr,
    input  logic [NPC_W-1:0]           txn_npc,
    input  logic [GAP_W-1:0]           txn_gap,
    input  logic                       stall,
    output logic                       enable_decode,
    output logic [INSTR_W-1:0]         instr_dout,
    output logic [NPC_W-1:0]           npc_in,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [15:0]                beats_sent
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StGap, StDrive} state_e;

    state_e               state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [INSTR_W-1:0]   pend_instr_q, pend_instr_d;
    logic [NPC_W-1:0]     pend_npc_q, pend_npc_d;
    logic                 enable_q, enable_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [NPC_W-1:0]     npc_q, npc_d;
    logic [15:0]          beats_q, beats_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;

    logic [INSTR_W-1:0]   mem_instr [DEPTH];
    logic [NPC_W-1:0]     mem_npc   [DEPTH];
    logic [GAP_W-1:0]     mem_gap   [DEPTH];

    logic                 push, pop;
    logic                 idle_en;
    logic [INSTR_W-1:0]   head_instr;
    logic [NPC_W-1:0]     head_npc;
    logic [GAP_W-1:0]     head_gap;

    assign txn_ready     = (count_q != CntW'(DEPTH));
    assign busy          = (state_q != StIdle) || (count_q != '0);
    assign enable_decode = enable_q;
    assign instr_dout    = instr_q;
    assign npc_in        = npc_q;
    assign fifo_count    = count_q;
    assign beats_sent    = beats_q;

    assign head_instr = mem_instr[rd_ptr_q];
    assign head_npc   = mem_npc[rd_ptr_q];
    assign head_gap   = mem_gap[rd_ptr_q];

    // Sticky mode keeps whatever enable level the last beat left; it never
    // raises enable on its own, so a freshly reset driver stays quiet.
    assign idle_en = STICKY_EN ? enable_q : 1'b0;

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        pend_instr_d = pend_instr_q;
        pend_npc_d   = pend_npc_q;
        enable_d     = enable_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        beats_d      = beats_q;
        pop          = 1'b0;

        if (!stall) begin
            unique case (state_q)
                StIdle, StDrive: begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                        if (head_gap == '0) begin
                            instr_d  = head_instr;
                            npc_d    = head_npc;
                            enable_d = 1'b1;
                            beats_d  = beats_q + 16'd1;
                            state_d  = StDrive;
                        end else begin
                            pend_instr_d = head_instr;
                            pend_npc_d   = head_npc;
                            gap_cnt_d    = head_gap;
                            enable_d     = idle_en;
                            state_d      = StGap;
                        end
                    end else begin
                        enable_d = idle_en;
                        state_d  = StIdle;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        instr_d  = pend_instr_q;
                        npc_d    = pend_npc_q;
                        enable_d = 1'b1;
                        beats_d  = beats_q + 16'd1;
                        state_d  = StDrive;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        push     = txn_valid && txn_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            gap_cnt_q    <= '0;
            pend_instr_q <= '0;
            pend_npc_q   <= '0;
            enable_q     <= 1'b0;
            instr_q      <= '0;
            npc_q        <= '0;
            beats_q      <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            pend_instr_q <= pend_instr_d;
            pend_npc_q   <= pend_npc_d;
            enable_q     <= enable_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
            beats_q      <= beats_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_instr[wr_ptr_q] <= txn_instr;
            mem_npc[wr_ptr_q]   <= txn_npc;
            mem_gap[wr_ptr_q]   <= txn_gap;
        end
    end

endmodule

// File: tb/tb_decode_in_txn_driver.sv
// Directed bench: a non-sticky and a sticky driver share one stimulus stream.
module tb_decode_in_txn_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        txn_valid;
    logic [15:0] txn_instr;
    logic [15:0] txn_npc;
    logic [3:0]  txn_gap;
    logic        stall;

    logic        txn_ready, enable_decode, busy;
    logic [15:0] instr_dout, npc_in, beats_sent;
    logic [2:0]  fifo_count;

    logic        s_txn_ready, s_enable_decode, s_busy;
    logic [15:0] s_instr_dout, s_npc_in, s_beats_sent;
    logic [2:0]  s_fifo_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    decode_in_txn_driver #(.STICKY_EN(1'b0)) dut (
        .clock(clock), .reset(reset), .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_instr(txn_instr), .txn_npc(txn_npc), .txn_gap(txn_gap), .stall(stall),
        .enable_decode(enable_decode), .instr_dout(instr_dout), .npc_in(npc_in),
        .busy(busy), .fifo_count(fifo_count), .beats_sent(beats_sent)
    );

    decode_in_txn_driver #(.STICKY_EN(1'b1)) dut_s (
        .clock(clock), .reset(reset), .txn_valid(txn_valid), .txn_ready(s_txn_ready),
        .txn_instr(txn_instr), .txn_npc(txn_npc), .txn_gap(txn_gap), .stall(stall),
        .enable_decode(s_enable_decode), .instr_dout(s_instr_dout), .npc_in(s_npc_in),
        .busy(s_busy), .fifo_count(s_fifo_count), .beats_sent(s_beats_sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] n,
                         input logic [3:0] g);
        txn_valid = v;
        txn_instr = i;
        txn_npc   = n;
        txn_gap   = g;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 4'h0);

        // Reset
        step();
        step();
        chk("rst_en", enable_decode, 0);
        chk("rst_instr", instr_dout, 0);
        chk("rst_npc", npc_in, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", txn_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_beats", beats_sent, 0);
        reset = 1'b0;
        step();
        chk("idle_en", enable_decode, 0);
        chk("idle_s_en", s_enable_decode, 0);

        // Single beat, gap 0
        drive(1'b1, 16'h1234, 16'h3001, 4'h0);
        step();
        chk("t2_count", fifo_count, 1);
        chk("t2_busy", busy, 1);
        chk("t2_en_pre", enable_decode, 0);
        drive(1'b0, 16'h0, 16'h0, 4'h0);
        step();
        chk("t2_en", enable_decode, 1);
        chk("t2_instr", instr_dout, 16'h1234);
        chk("t2_npc", npc_in, 16'h3001);
        chk("t2_beats1", beats_sent, 1);
        step();
        chk("t2_en_off", enable_decode, 0);
        chk("t2_hold_instr", instr_dout, 16'h1234);
        chk("t2_hold_npc", npc_in, 16'h3001);
        chk("t2_beats", beats_sent, 1);
        chk("t2_busy_off", busy, 0);

        // Back-to-back beats
        drive(1'b1, 16'h1111, 16'h2111, 4'h0);
        step();
        drive(1'b1, 16'h1112, 16'h2112, 4'h0);
        step();
        chk("t3_b0_en", enable_decode, 1);
        chk("t3_b0", instr_dout, 16'h1111);
        drive(1'b1, 16'h1113, 16'h2113, 4'h0);
        step();
        chk("t3_b1_en", enable_decode, 1);
        chk("t3_b1", instr_dout, 16'h1112);
        drive(1'b0, 16'h0, 16'h0, 4'h0);
        step();
        chk("t3_b2_en", enable_decode, 1);
        chk("t3_b2", instr_dout, 16'h1113);
        chk("t3_b2_npc", npc_in, 16'h2113);
        chk("t3_beats", beats_sent, 4);
        chk("t3_busy_last", busy, 1);
        step();
        chk("t3_en_off", enable_decode, 0);
        chk("t3_busy_off", busy, 0);

        // Gap of 2 between A and B
        drive(1'b1, 16'hAAAA, 16'hA001, 4'h0);
        step();
        drive(1'b1, 16'hBBBB, 16'hB002, 4'h2);
        step();
        chk("t4_a_en", enable_decode, 1);
        chk("t4_a", instr_dout, 16'hAAAA);
        drive(1'b0, 16'h0, 16'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t4_gap_en", enable_decode, 0);
            chk("t4_gap_instr", instr_dout, 16'hAAAA);
            chk("t4_gap_s_en", s_enable_decode, 1);
            chk("t4_gap_s_instr", s_instr_dout, 16'hAAAA);
            chk("t4_gap_s_npc", s_npc_in, 16'hA001);
        end
        step();
        chk("t4_b_en", enable_decode, 1);
        chk("t4_b", instr_dout, 16'hBBBB);
        chk("t4_b_npc", npc_in, 16'hB002);
        chk("t4_b_s", s_instr_dout, 16'hBBBB);
        chk("t4_beats", beats_sent, 6);
        step();
        chk("t4_en_off", enable_decode, 0);
        chk("t4_s_en_hold", s_enable_decode, 1);
        chk("t4_s_instr_hold", s_instr_dout, 16'hBBBB);

        // Fill while stalled, then drain
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'h5000 + 16'(k), 16'h6000 + 16'(k), 4'h0);
            step();
            if (k == 3) begin
                chk("t5_ready_full", txn_ready, 0);
                chk("t5_count_full", fifo_count, 4);
            end
        end
        chk("t5_count", fifo_count, 4);
        chk("t5_frozen_en", enable_decode, 0);
        chk("t5_frozen_instr", instr_dout, 16'hBBBB);
        chk("t5_frozen_beats", beats_sent, 6);
        chk("t5_frozen_s_en", s_enable_decode, 1);
        chk("t5_busy", busy, 1);
        stall = 1'b0;
        step();
        chk("t5_r0_en", enable_decode, 1);
        chk("t5_r0", instr_dout, 16'h5000);
        chk("t5_r0_count", fifo_count, 3);
        step();
        chk("t5_r1", instr_dout, 16'h5001);
        chk("t5_r1_count", fifo_count, 3);
        drive(1'b0, 16'h0, 16'h0, 4'h0);
        for (int k = 2; k < 5; k++) begin
            step();
            chk("t5_rn_en", enable_decode, 1);
            chk("t5_rn", instr_dout, 16'h5000 + 16'(k));
            chk("t5_rn_npc", npc_in, 16'h6000 + 16'(k));
        end
        chk("t5_beats", beats_sent, 11);
        chk("t5_count_empty", fifo_count, 0);
        step();
        chk("t5_en_off", enable_decode, 0);
        chk("t5_busy_off", busy, 0);

        // Reset during a gap discards the pending beat
        drive(1'b1, 16'h7777, 16'h7001, 4'h3);
        step();
        drive(1'b0, 16'h0, 16'h0, 4'h0);
        step();
        chk("t6_gap_busy", busy, 1);
        chk("t6_gap_en", enable_decode, 0);
        step();
        reset = 1'b1;
        step();
        chk("t6_rst_en", enable_decode, 0);
        chk("t6_rst_instr", instr_dout, 0);
        chk("t6_rst_npc", npc_in, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_beats", beats_sent, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", txn_ready, 1);
        chk("t6_rst_s_en", s_enable_decode, 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t6_no_beat_en", enable_decode, 0);
            chk("t6_no_beat_instr", instr_dout, 0);
            chk("t6_no_beat_beats", beats_sent, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
